// File: rtl/mult_pkg.sv
// Shared constants for the 32-bit multiplier-result link. The 64->32 slicer and
// the 32->64 packer both import this, so word and product widths always agree.
// Contents: WORD_W, PROD_W, the pair-phase enum and a pair assembly helper.
package mult_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned PROD_W = 64;

  // Position of the next expected word inside a product pair.
  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_e;

  // Combine the two link words of a pair into a product, given wire order.
  function automatic logic [PROD_W-1:0] pack_pair(input logic [WORD_W-1:0] first_word,
                                                  input logic [WORD_W-1:0] second_word,
                                                  input bit              msb_first);
    return msb_first ? {first_word, second_word} : {second_word, first_word};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc_i pulses, sticks at all-ones, never wraps.
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   synchronous active-low reset, clears the count
//   inc_i    increment request for this cycle
//   count_o  current count
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/packer_32x64.sv
// Rebuilds 64-bit products from a stream of 32-bit halves at the receive end of
// the multiplier-result link. The first half waits in a hold register; the
// completed pair lands in a registered output stage, so the first half of the
// next pair can be taken while the previous product waits for the sink.
// Ports:
//   clk           clock, rising edge
//   rst_n         synchronous active-low reset
//   clear         flush a held first half; blocks input for this cycle
//   in_data       product half            in_valid / in_ready   input handshake
//   out_data      assembled product       out_valid / out_ready output handshake
//   pair_count    delivered pairs, saturating
//   half_pending  first half held, second half awaited
module packer_32x64
  import mult_pkg::*;
#(
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [PROD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  pair_count,
  output logic              half_pending
);

  phase_e            phase_d, phase_q;
  logic [WORD_W-1:0] hold_d, hold_q;
  logic [PROD_W-1:0] out_data_d, out_data_q;
  logic              out_valid_d, out_valid_q;

  logic in_xfer;
  logic out_xfer;
  logic load_out;

  // Second half may only enter when the output stage is empty or draining now.
  always_comb begin
    in_ready = 1'b0;
    if (!clear) begin
      in_ready = (phase_q == PH_FIRST) ? 1'b1 : (!out_valid_q || out_ready);
    end
  end

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;
  assign load_out = in_xfer && (phase_q == PH_SECOND);

  always_comb begin
    phase_d     = phase_q;
    hold_d      = hold_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (clear) begin
      phase_d = PH_FIRST;
    end else if (in_xfer) begin
      unique case (phase_q)
        PH_FIRST: begin
          hold_d  = in_data;
          phase_d = PH_SECOND;
        end
        PH_SECOND: begin
          phase_d = PH_FIRST;
        end
        default: phase_d = PH_FIRST;
      endcase
    end

    // A reload in the same cycle as a drain keeps out_valid high.
    if (load_out) begin
      out_data_d  = pack_pair(hold_q, in_data, MSB_FIRST);
      out_valid_d = 1'b1;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q     <= PH_FIRST;
      hold_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  sat_counter #(
    .Width (CNT_W)
  ) u_pair_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .inc_i   (out_xfer),
    .count_o (pair_count)
  );

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign half_pending = (phase_q == PH_SECOND);

endmodule
